// File: rtl/wb_sdram_burst_master.sv
// Wishbone incrementing-burst master feeding the SDRAM controller's slave port.
// Accepts read/write burst commands on a valid/ready queue, streams write beats
// in and read beats out, and aborts a beat the controller never acknowledges.
module wb_sdram_burst_master #(
  parameter int APP_AW  = 26,
  parameter int dw      = 32,
  parameter int MAX_BL  = 8,
  parameter int TIMEOUT = 255,
  parameter int LW      = $clog2(MAX_BL) + 1
) (
  input  logic              sys_clk,
  input  logic              wb_rst_i,
  input  logic              sdr_init_done,
  // command queue
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [APP_AW-1:0] cmd_addr,
  input  logic [LW-1:0]     cmd_len,
  input  logic [dw/8-1:0]   cmd_sel,
  // write data stream
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [dw-1:0]     wdata,
  // read data stream and completion
  output logic              rdata_valid,
  output logic [dw-1:0]     rdata,
  output logic              done,
  output logic              err,
  // Wishbone master
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [2:0]        wb_cti_o,
  output logic [APP_AW-1:0] wb_adr_o,
  output logic [dw-1:0]     wb_dat_o,
  output logic [dw/8-1:0]   wb_sel_o,
  input  logic              wb_ack_i,
  input  logic [dw-1:0]     wb_dat_i
);

  localparam int                TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [APP_AW-1:0] ADR_STEP = APP_AW'(dw / 8);
  localparam logic [2:0]        CTI_NONE = 3'b000;
  localparam logic [2:0]        CTI_INC  = 3'b010;
  localparam logic [2:0]        CTI_EOB  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WDATA,
    S_BUS,
    S_FINISH
  } state_e;

  state_e              state_q;
  logic [LW-1:0]       rem_q;        // beats still to be acked, current one included
  logic [TW-1:0]       tmo_q;        // consecutive un-acked strobe cycles
  logic                cyc_q;
  logic                stb_q;
  logic                we_q;
  logic [2:0]          cti_q;
  logic [APP_AW-1:0]   adr_q;
  logic [dw-1:0]       dat_q;
  logic [dw/8-1:0]     sel_q;
  logic                wdata_ready_q;
  logic                rdata_valid_q;
  logic [dw-1:0]       rdata_q;
  logic                done_q;
  logic                err_q;
  logic                beat_ack;

  // A beat completes only on a qualified strobe.
  assign beat_ack = cyc_q && stb_q && wb_ack_i;

  // Command acceptance is immediate once init is done, so it is decoded from state.
  assign cmd_ready   = (state_q == S_IDLE) && sdr_init_done && !wb_rst_i;

  assign wdata_ready = wdata_ready_q;
  assign rdata_valid = rdata_valid_q;
  assign rdata       = rdata_q;
  assign done        = done_q;
  assign err         = err_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = stb_q;
  assign wb_we_o     = we_q;
  assign wb_cti_o    = cti_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;

  // Burst sequencer: command latch, beat handshakes, timeout abort, completion pulse.
  always_ff @(posedge sys_clk) begin
    // NOTE: state is updated with non-blocking assignments so every branch below
    // reads the pre-edge value of the registers, regardless of statement order.
    if (wb_rst_i) begin
      state_q       <= S_IDLE;
      rem_q         <= '0;
      tmo_q         <= '0;
      cyc_q         <= 1'b0;
      stb_q         <= 1'b0;
      we_q          <= 1'b0;
      cti_q         <= CTI_NONE;
      adr_q         <= '0;
      dat_q         <= '0;
      sel_q         <= '0;
      wdata_ready_q <= 1'b0;
      rdata_valid_q <= 1'b0;
      rdata_q       <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      // Single-cycle strobes default low and are raised only by the edge that earns them.
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (cmd_valid && sdr_init_done) begin
            adr_q <= cmd_addr;
            sel_q <= cmd_sel;
            we_q  <= cmd_we;
            rem_q <= cmd_len;
            tmo_q <= '0;
            if (cmd_len == '0) begin
              state_q <= S_FINISH;
              done_q  <= 1'b1;
            end else begin
              cyc_q <= 1'b1;
              cti_q <= (cmd_len == LW'(1)) ? CTI_EOB : CTI_INC;
              if (cmd_we) begin
                state_q       <= S_WDATA;
                wdata_ready_q <= 1'b1;
              end else begin
                state_q <= S_BUS;
                stb_q   <= 1'b1;
              end
            end
          end
        end

        S_WDATA: begin
          tmo_q <= '0;
          if (wdata_valid) begin
            dat_q         <= wdata;
            wdata_ready_q <= 1'b0;
            stb_q         <= 1'b1;
            state_q       <= S_BUS;
          end
        end

        S_BUS: begin
          if (beat_ack) begin
            tmo_q <= '0;
            adr_q <= adr_q + ADR_STEP;
            rem_q <= rem_q - LW'(1);
            if (!we_q) begin
              rdata_q       <= wb_dat_i;
              rdata_valid_q <= 1'b1;
            end
            if (rem_q == LW'(1)) begin
              cyc_q   <= 1'b0;
              stb_q   <= 1'b0;
              cti_q   <= CTI_NONE;
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end else begin
              cti_q <= (rem_q == LW'(2)) ? CTI_EOB : CTI_INC;
              if (we_q) begin
                stb_q         <= 1'b0;
                wdata_ready_q <= 1'b1;
                state_q       <= S_WDATA;
              end
            end
          end else if (tmo_q == TMO_LAST) begin
            // The slave has gone silent: abandon the rest of the command.
            tmo_q   <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            cti_q   <= CTI_NONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end

        S_FINISH: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
